// File: rtl/multicycle_cpu.sv
// Multicycle accumulator-free CPU: IDLE/EXEC/MEM/WB/HALT sequencer around a small
// register file, single-port data memory and flag-producing ALU.
module multicycle_cpu #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_BITS   = 5,
    parameter int unsigned REG_BITS    = 2,
    parameter int unsigned INSTR_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    output logic                   done,
    output logic                   halted,
    output logic                   zero_flag,
    output logic                   carry_flag,
    input  logic [REG_BITS-1:0]    dbg_sel,
    output logic [DATA_WIDTH-1:0]  dbg_data
);

    localparam int unsigned DW      = DATA_WIDTH;
    localparam int unsigned AW      = ADDR_BITS;
    localparam int unsigned RB      = REG_BITS;
    localparam int unsigned IW      = INSTR_WIDTH;
    localparam int unsigned NREG    = 2 ** RB;
    localparam int unsigned DEPTH   = 2 ** AW;
    localparam int unsigned OP_LSB  = IW - 4;
    localparam int unsigned RD_LSB  = OP_LSB - RB;
    localparam int unsigned RS1_LSB = RD_LSB - RB;
    localparam int unsigned RS2_LSB = RS1_LSB - RB;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_LD   = 4'd9;
    localparam logic [3:0] OP_ST   = 4'd10;
    localparam logic [3:0] OP_MOVI = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t state_q, state_d;
    logic   done_d;

    logic [IW-1:0] instr_q;
    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] mem  [DEPTH];
    logic [DW-1:0] result_q;
    logic          carry_q;
    logic [AW-1:0] addr_q;

    logic [3:0]    op;
    logic [RB-1:0] rd, rs1, rs2;
    logic [DW-1:0] imm, opa, opb, addr_sum;
    logic [DW:0]   alu_wide;
    logic          accept, store_en, wb_en;

    assign op  = instr_q[IW-1 -: 4];
    assign rd  = instr_q[RD_LSB  +: RB];
    assign rs1 = instr_q[RS1_LSB +: RB];
    assign rs2 = instr_q[RS2_LSB +: RB];
    assign imm = instr_q[DW-1:0];
    assign opa = regs[rs1];
    assign opb = regs[rs2];

    assign accept   = (state_q == S_IDLE) && instr_valid;
    assign store_en = (state_q == S_MEM) && (op == OP_ST) && rst;
    assign wb_en    = (state_q == S_WB);
    assign addr_sum = opa + imm;
    assign dbg_data = regs[dbg_sel];

    // Instruction bits between the register fields and imm are don't-care.
    logic unused_bits;
    assign unused_bits = ^{instr_q, addr_sum};

    // ALU: one extra bit carries add carry, subtract borrow or shifted-out bit.
    always_comb begin
        alu_wide = '0;
        case (op)
            OP_ADD:  alu_wide = {1'b0, opa} + {1'b0, opb};
            OP_SUB:  alu_wide = {1'b0, opa} - {1'b0, opb};
            OP_AND:  alu_wide = {1'b0, opa & opb};
            OP_OR:   alu_wide = {1'b0, opa | opb};
            OP_XOR:  alu_wide = {1'b0, opa ^ opb};
            OP_SHL:  alu_wide = {opa, 1'b0};
            OP_SHR:  alu_wide = {opa[0], 1'b0, opa[DW-1:1]};
            OP_ADDI: alu_wide = {1'b0, opa} + {1'b0, imm};
            OP_MOVI: alu_wide = {1'b0, imm};
            default: alu_wide = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer: next state plus the retirement pulse.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                    OP_SHL, OP_SHR, OP_ADDI, OP_MOVI: state_d = S_WB;
                    OP_LD, OP_ST: state_d = S_MEM;
                    OP_HALT: begin
                        state_d = S_HALT;
                        done_d  = 1'b1;
                    end
                    default: begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (op == OP_ST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_ready <= 1'b1;
            done        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            instr_ready <= (state_d == S_IDLE);
            done        <= done_d;
            halted      <= (state_d == S_HALT);
        end
    end

    // Datapath: instruction latch, EXEC/MEM staging, register file and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q    <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            addr_q     <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (accept) begin
                instr_q <= instruction;
            end
            if (state_q == S_EXEC) begin
                result_q <= alu_wide[DW-1:0];
                carry_q  <= alu_wide[DW];
                addr_q   <= addr_sum[AW-1:0];
            end
            if ((state_q == S_MEM) && (op == OP_LD)) begin
                result_q <= mem[addr_q];
            end
            if (wb_en) begin
                regs[rd] <= result_q;
                if (op != OP_LD) begin
                    zero_flag  <= (result_q == '0);
                    carry_flag <= carry_q;
                end
            end
        end
    end

    // Data memory keeps its contents across reset; rst gates a store caught mid-flight.
    always_ff @(posedge clk) begin
        if (store_en) begin
            mem[addr_q] <= opb;
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: ALU flags, memory wrap, back-to-back handshake,
// HALT stickiness and reset behaviour, with hand-computed expectations.
module tb_multicycle_cpu;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        done;
    logic        halted;
    logic        zero_flag;
    logic        carry_flag;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int errors = 0;
    int checks = 0;

    multicycle_cpu dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .done        (done),
        .halted      (halted),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2,
                                        input logic [7:0] imm);
        return {op, rd, rs1, rs2, 2'b00, imm};
    endfunction

    // Issue one instruction and return cycles from accept edge to done (0 = timeout).
    task automatic exec_instr(input logic [19:0] w, output int lat);
        int guard;
        guard = 0;
        lat   = 0;
        @(negedge clk);
        while (!instr_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        instruction = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic read_reg(input logic [1:0] idx, output logic [7:0] val);
        dbg_sel = idx;
        #1;
        val = dbg_data;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        rst = 1'b0;
        instr_valid = 1'b0;
        instruction = '0;
        dbg_sel = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
        checks++;
        if ({done, halted, zero_flag, carry_flag} !== 4'b0000) begin
            errors++; $display("FAIL reset_status: got %b expected 0000", {done, halted, zero_flag, carry_flag});
        end
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), v);
            checks++;
            if (v !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h expected 00", i, v); end
        end
    endtask

    task automatic test_alu;
        int lat;
        logic [7:0] v;
        exec_instr(enc(4'd11, 2'd1, 2'd0, 2'd0, 8'hF0), lat);
        checks++;
        if (lat != 2) begin errors++; $display("FAIL movi_latency: got %0d expected 2", lat); end
        read_reg(2'd1, v);
        checks++;
        if (v !== 8'hF0) begin errors++; $display("FAIL movi_r1: got %h expected f0", v); end
        exec_instr(enc(4'd11, 2'd2, 2'd0, 2'd0, 8'h20), lat);
        exec_instr(enc(4'd1, 2'd3, 2'd1, 2'd2, 8'h00), lat);
        checks++;
        if (lat != 2) begin errors++; $display("FAIL add_latency: got %0d expected 2", lat); end
        read_reg(2'd3, v);
        checks++;
        if (v !== 8'h10) begin errors++; $display("FAIL add_r3: got %h expected 10", v); end
        checks++;
        if ({zero_flag, carry_flag} !== 2'b01) begin
            errors++; $display("FAIL add_flags: got z/c %b expected 01", {zero_flag, carry_flag});
        end
    endtask

    task automatic test_sub_shift;
        int lat;
        logic [7:0] v;
        exec_instr(enc(4'd2, 2'd0, 2'd2, 2'd2, 8'h00), lat);
        read_reg(2'd0, v);
        checks++;
        if (v !== 8'h00 || {zero_flag, carry_flag} !== 2'b10) begin
            errors++; $display("FAIL sub_self: got r0=%h z/c=%b expected 00 10", v, {zero_flag, carry_flag});
        end
        exec_instr(enc(4'd2, 2'd3, 2'd0, 2'd2, 8'h00), lat);
        read_reg(2'd3, v);
        checks++;
        if (v !== 8'hE0 || {zero_flag, carry_flag} !== 2'b01) begin
            errors++; $display("FAIL sub_borrow: got r3=%h z/c=%b expected e0 01", v, {zero_flag, carry_flag});
        end
        exec_instr(enc(4'd11, 2'd1, 2'd0, 2'd0, 8'h81), lat);
        exec_instr(enc(4'd6, 2'd3, 2'd1, 2'd0, 8'h00), lat);
        read_reg(2'd3, v);
        checks++;
        if (v !== 8'h02 || {zero_flag, carry_flag} !== 2'b01) begin
            errors++; $display("FAIL shl: got r3=%h z/c=%b expected 02 01", v, {zero_flag, carry_flag});
        end
        exec_instr(enc(4'd7, 2'd3, 2'd1, 2'd0, 8'h00), lat);
        read_reg(2'd3, v);
        checks++;
        if (v !== 8'h40 || {zero_flag, carry_flag} !== 2'b01) begin
            errors++; $display("FAIL shr: got r3=%h z/c=%b expected 40 01", v, {zero_flag, carry_flag});
        end
        exec_instr(enc(4'd5, 2'd3, 2'd1, 2'd1, 8'h00), lat);
        read_reg(2'd3, v);
        checks++;
        if (v !== 8'h00 || {zero_flag, carry_flag} !== 2'b10) begin
            errors++; $display("FAIL xor_self: got r3=%h z/c=%b expected 00 10", v, {zero_flag, carry_flag});
        end
        exec_instr(enc(4'd8, 2'd3, 2'd1, 2'd0, 8'h7F), lat);
        read_reg(2'd3, v);
        checks++;
        if (v !== 8'h00 || {zero_flag, carry_flag} !== 2'b11) begin
            errors++; $display("FAIL addi_wrap: got r3=%h z/c=%b expected 00 11", v, {zero_flag, carry_flag});
        end
        exec_instr(enc(4'd0, 2'd3, 2'd1, 2'd1, 8'h00), lat);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL nop_latency: got %0d expected 1", lat); end
    endtask

    task automatic test_mem;
        int lat;
        logic [7:0] v;
        exec_instr(enc(4'd11, 2'd1, 2'd0, 2'd0, 8'h01), lat);
        exec_instr(enc(4'd10, 2'd0, 2'd1, 2'd2, 8'h1F), lat);
        checks++;
        if (lat != 2) begin errors++; $display("FAIL st_latency: got %0d expected 2", lat); end
        exec_instr(enc(4'd8, 2'd3, 2'd1, 2'd0, 8'hFF), lat);
        exec_instr(enc(4'd9, 2'd3, 2'd0, 2'd0, 8'h00), lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL ld_latency: got %0d expected 3", lat); end
        read_reg(2'd3, v);
        checks++;
        if (v !== 8'h20) begin errors++; $display("FAIL ld_wrap_data: got %h expected 20", v); end
        checks++;
        if ({zero_flag, carry_flag} !== 2'b11) begin
            errors++; $display("FAIL ld_flags_kept: got z/c %b expected 11", {zero_flag, carry_flag});
        end
        exec_instr(enc(4'd1, 2'd1, 2'd1, 2'd1, 8'h00), lat);
        read_reg(2'd1, v);
        checks++;
        if (v !== 8'h02) begin errors++; $display("FAIL add_rd_eq_rs: got %h expected 02", v); end
    endtask

    task automatic test_back_to_back;
        logic [19:0] prog [5];
        int accepts, dones, busy_bad;
        logic acc;
        logic [7:0] v;
        prog[0] = enc(4'd11, 2'd0, 2'd0, 2'd0, 8'h11);
        prog[1] = enc(4'd11, 2'd1, 2'd0, 2'd0, 8'h22);
        prog[2] = enc(4'd1,  2'd2, 2'd0, 2'd1, 8'h00);
        prog[3] = enc(4'd10, 2'd0, 2'd0, 2'd2, 8'h01);
        prog[4] = enc(4'd9,  2'd3, 2'd1, 2'd0, 8'hF0);
        accepts = 0;
        dones = 0;
        busy_bad = 0;
        instruction = prog[0];
        instr_valid = 1'b1;
        for (int cyc = 0; cyc < 200 && dones < 5; cyc++) begin
            @(negedge clk);
            acc = instr_valid && instr_ready;
            @(posedge clk);
            #1;
            if (done) dones++;
            if (instr_ready !== done) busy_bad++;
            if (acc) begin
                accepts++;
                if (accepts < 5) instruction = prog[accepts];
                else instr_valid = 1'b0;
            end
        end
        instr_valid = 1'b0;
        checks++;
        if (accepts != 5 || dones != 5) begin
            errors++; $display("FAIL b2b_counts: got accepts=%0d dones=%0d expected 5 5", accepts, dones);
        end
        checks++;
        if (busy_bad != 0) begin errors++; $display("FAIL b2b_ready_busy: got %0d bad cycles expected 0", busy_bad); end
        read_reg(2'd2, v);
        checks++;
        if (v !== 8'h33) begin errors++; $display("FAIL b2b_r2: got %h expected 33", v); end
        read_reg(2'd3, v);
        checks++;
        if (v !== 8'h33) begin errors++; $display("FAIL b2b_r3: got %h expected 33", v); end
    endtask

    task automatic test_reset_mem;
        int lat;
        logic [7:0] v;
        exec_instr(enc(4'd11, 2'd0, 2'd0, 2'd0, 8'h05), lat);
        exec_instr(enc(4'd11, 2'd1, 2'd0, 2'd0, 8'hAA), lat);
        exec_instr(enc(4'd10, 2'd0, 2'd0, 2'd1, 8'h00), lat);
        exec_instr(enc(4'd11, 2'd1, 2'd0, 2'd0, 8'h55), lat);
        @(negedge clk);
        instruction = enc(4'd10, 2'd0, 2'd0, 2'd1, 8'h00);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL rst_in_mem_state: got ready=%b done=%b expected 1 0", instr_ready, done);
        end
        @(negedge clk);
        rst = 1'b1;
        exec_instr(enc(4'd11, 2'd0, 2'd0, 2'd0, 8'h05), lat);
        exec_instr(enc(4'd9, 2'd2, 2'd0, 2'd0, 8'h00), lat);
        read_reg(2'd2, v);
        checks++;
        if (v !== 8'hAA) begin errors++; $display("FAIL rst_suppress_store: got %h expected aa", v); end
    endtask

    task automatic test_halt;
        int lat, extra_done, ready_seen;
        logic [7:0] v;
        exec_instr(enc(4'd11, 2'd2, 2'd0, 2'd0, 8'h77), lat);
        exec_instr(enc(4'd15, 2'd0, 2'd0, 2'd0, 8'h00), lat);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL halt_latency: got %0d expected 1", lat); end
        checks++;
        if (halted !== 1'b1 || instr_ready !== 1'b0) begin
            errors++; $display("FAIL halt_state: got halted=%b ready=%b expected 1 0", halted, instr_ready);
        end
        extra_done = 0;
        ready_seen = 0;
        instruction = enc(4'd0, 2'd0, 2'd0, 2'd0, 8'h00);
        instr_valid = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
            if (instr_ready || !halted) ready_seen++;
        end
        checks++;
        if (extra_done != 0 || ready_seen != 0) begin
            errors++; $display("FAIL halt_sticky: got done=%0d ready_or_unhalt=%0d expected 0 0", extra_done, ready_seen);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        read_reg(2'd2, v);
        checks++;
        if (halted !== 1'b0 || v !== 8'h00) begin
            errors++; $display("FAIL halt_reset: got halted=%b r2=%h expected 0 00", halted, v);
        end
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL halt_release_ready: got %b expected 1", instr_ready); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_sub_shift();
        test_mem();
        test_back_to_back();
        test_reset_mem();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 Parameter DATA_WIDTH, default 8: datapath, register and memory word width.
REQ-002 Parameter ADDR_BITS, default 5: data memory address width; depth 2**ADDR_BITS words.
REQ-003 Parameter REG_BITS, default 2: register index width; 2**REG_BITS registers.
REQ-004 Parameter INSTR_WIDTH, default 20: instruction width, SHALL be >= 4+3*REG_BITS+DATA_WIDTH.
REQ-005 clk  input  1  single clock; all state on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 instruction  input  INSTR_WIDTH  fields MSB-down: opcode[4], rd, rs1, rs2 (REG_BITS each); imm = low DATA_WIDTH bits; remaining bits ignored.
REQ-008 instr_valid  input  1  instruction word present.
REQ-009 instr_ready  output  1  block accepts an instruction this cycle.
REQ-010 done  output  1  one-cycle pulse on instruction retirement.
REQ-011 halted  output  1  HALT retired; sticky until reset.
REQ-012 zero_flag, carry_flag  output  1 each  status from last ALU-class instruction.
REQ-013 dbg_sel  input  REG_BITS  debug register select.
REQ-014 dbg_data  output  DATA_WIDTH  combinational read of register dbg_sel.

Function
REQ-015 States: IDLE, EXEC, MEM, WB, HALT; instr_ready SHALL be 1 only in IDLE.
REQ-016 Accept on instr_valid && instr_ready rising edge: latch instruction, IDLE->EXEC; no accept in any other state.
REQ-017 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL (rs1<<1), 7 SHR (rs1>>1), 8 ADDI (rs1+imm), 9 LD rd<=mem[rs1+imm], 10 ST mem[rs1+imm]<=rs2, 11 MOVI rd<=imm, 15 HALT; 12-14 execute as NOP.
REQ-018 EXEC: result/address registered; ALU-class (1-8, 11) -> WB; LD/ST -> MEM; NOP -> IDLE with done; HALT -> HALT with done.
REQ-019 MEM: ST writes memory and -> IDLE with done; LD registers read data and -> WB.
REQ-020 WB: write rd, -> IDLE, done=1.
REQ-021 Latency from accept edge to done: NOP/HALT 1 cycle, ALU 2, ST 2, LD 3; next accept on the cycle after done at earliest.
REQ-022 ADD/SUB/ADDI computed DATA_WIDTH+1 wide; result truncated to DATA_WIDTH; carry_flag = bit DATA_WIDTH (SUB: 1 = borrow).
REQ-023 Logic/shift/MOVI: carry_flag = 0 except SHL (shifted-out MSB) and SHR (shifted-out LSB).
REQ-024 zero_flag = (written result == 0); flags update on the WB edge of ALU-class instructions only; LD/ST/NOP leave flags unchanged.
REQ-025 Memory address = (rs1+imm) mod 2**ADDR_BITS (silent wrap-around).
REQ-026 Register 0 is general purpose (not hardwired); rd == rs1 reads the old value.
REQ-027 HALT state: instr_ready=0, halted=1, done=0, no further state change until reset.
REQ-028 instr_valid while not ready is ignored; source holds the word until accepted.
REQ-029 dbg_data reflects a register write in the cycle after the WB edge.

Reset
REQ-030 rst low SHALL immediately force IDLE, instr_ready=1 (once released), done=0, halted=0, flags=0, all registers=0.
REQ-031 Reset during MEM of ST SHALL suppress the memory write; data memory contents are not reset.

Verification
REQ-032 MOVI r1,0xF0; MOVI r2,0x20; ADD r3,r1,r2 -> dbg r3=0x10, carry=1, zero=0, done 2 cycles after each accept.
REQ-033 SUB r0,r2,r2 -> r0=0x00, zero=1, carry=0; SHL of 0x81 -> 0x02, carry=1.
REQ-034 ST r2 at r1+0x1F with r1=0x01 -> address 0x00 (wrap); LD r3,[r0+0x00] with r0=0 -> r3=0x20, done 3 cycles after accept, flags unchanged.
REQ-035 instr_valid held high continuously -> instr_ready low in EXEC/MEM/WB, exactly one accept per retirement, no instruction dropped or duplicated.
REQ-036 HALT then valid NOPs -> done pulse once, halted=1, instr_ready stays 0; rst low -> halted=0, registers 0.
REQ-037 rst asserted in MEM of ST to address 0x05 (preloaded 0xAA) -> mem[0x05] still 0xAA on later LD.
